fas16_seq_arb: RTL
==================

// Module: fas16_seq_arb
// PURPOSE
//  Time-shares one combinational 16-bit adder (inverted carry-in/out) between two requesters.
//  Sequences 16-bit ops in one adder pass and 32-bit ops in two passes, chaining the carry internally.
//  Sits between requester pipelines and a single adder instance; all operand and result registers live here.
// PARAMETERS
//  W32_EN  1  1: op32 honoured (two-pass 32-bit add); 0: op32 ignored, every op is 16-bit
//  PRIO    0  0: round-robin between req0/req1; 1: fixed priority, req0 always wins
// PORTS
//  sys_clk    in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  req0/req1  in   1   operation request; transfer when reqN & gntN
//  gnt0/gnt1  out  1   combinational accept; high only in IDLE, at most one set
//  op32_0/1   in   1   1 = 32-bit op, sampled at transfer
//  a0/a1      in   32  operand A, sampled at transfer (bits 31:16 ignored for 16-bit ops)
//  b0/b1      in   32  operand B, sampled at transfer
//  cin0/1     in   1   active-high carry-in to bit 0, sampled at transfer
//  done0/1    out  1   one-cycle pulse, result valid for owning requester
//  res0/1     out  32  result, registered, holds until that requester's next done
//  cout0/1    out  1   active-high carry out of msb of the op (bit 15 or 31)
//  add_a      out  16  adder operand A half
//  add_b      out  16  adder operand B half
//  add_ci_n   out  1   adder carry-in, inverted (0 = carry)
//  add_s      in   16  adder sum
//  add_co_n   in   1   adder carry-out, inverted (0 = carry)
// BEHAVIOUR
//  - Reset: state IDLE, gnt*=0, done*=0, res*=0, cout*=0, add_a=add_b=0, add_ci_n=1, rr pointer=1 (req0 wins first).
//  - FSM IDLE -> LO -> (HI) -> IDLE. IDLE: gnt asserted to winner; on transfer latch owner, op32, A, B, cin; -> LO.
//  - Arbitration: single request wins; both: PRIO=1 -> req0; PRIO=0 -> requester not served last; pointer updates on transfer.
//  - LO: add_a=A[15:0], add_b=B[15:0], add_ci_n=~cin. Edge: res[15:0]<=add_s, c_lo<=~add_co_n.
//    16-bit: res[31:16]<=0, cout<=~add_co_n, done pulse next cycle, -> IDLE. 32-bit: -> HI.
//  - HI: add_a=A[31:16], add_b=B[31:16], add_ci_n=~c_lo. Edge: res[31:16]<=add_s, cout<=~add_co_n, done pulse, -> IDLE.
//  - Latency (transfer in cycle N): 16-bit done in N+2, 32-bit done in N+3. done cycle is IDLE, so next transfer may occur in it.
//  - Throughput: one 16-bit op per 2 cycles, one 32-bit op per 3 cycles; loser waits, gnt stays low outside IDLE.
//  - Outside LO/HI adder inputs drive 0 and add_ci_n=1; add_s/add_co_n ignored.
//  - Only owner's res/cout/done update; other requester's result registers hold.
//  - Sums are modulo 2^16 / 2^32; overflow reported only via cout (unless saturation enabled).
//  - Request dropped before grant: no effect. Operand change after transfer: no effect.
//  - Reset mid-op: immediate return to reset state; op discarded, no done pulse, pointer back to 1.
//  - W32_EN=0: HI state unreachable; all ops take 16-bit path.
// CONFIGURATION
//  FAS16_SEQ_SAT_EN defined: unsigned saturation; if final cout=1, owner's result forced to all ones
//    (0xFFFF in [15:0] with [31:16]=0 for 16-bit; 0xFFFFFFFF for 32-bit); cout still reported 1.
//  Undefined: wrap-around result, no saturation logic built.
// TESTING
//  1. req0 16-bit A=0x1234 B=0x0FFF cin=0, transfer N -> done0 in N+2, res0=0x00002233, cout0=0, add_ci_n=1 in LO.
//  2. req1 32-bit A=0x0000FFFF B=0x00000001 -> add_ci_n=0 in HI, done1 in N+3, res1=0x00010000, cout1=0.
//  3. req0+req1 16-bit same cycle after reset, both held -> req0 first, req1 transfers in req0's done cycle;
//     repeat both -> req0 served next (rr alternates); PRIO=1 with both held -> req1 starves.
//  4. 16-bit 0xFFFF+0x0001 cin=1 -> res=0x00000001, cout=1; with FAS16_SEQ_SAT_EN -> res=0x0000FFFF, cout=1.
//  5. 32-bit 0xFFFFFFFF+0x00000001 -> res=0, cout=1; with FAS16_SEQ_SAT_EN -> res=0xFFFFFFFF.
//  6. reset pulse in HI of 32-bit op -> no done, outputs at reset values, next simultaneous request grants req0.

Source files
------------

// File: rtl/fas16_seq_arb_if.sv
// fas16_seq_arb_if: requester handshakes plus external adder connection for fas16_seq_arb
// slave: the sequencer view (takes requests, drives the adder); master: requesters and adder side.
// Signals: req/gnt/op32/a/b/cin in, done/res/cout out per requester; add_a/add_b/add_ci_n to the adder, add_s/add_co_n back.
interface fas16_seq_arb_if;
    logic        req0, req1, gnt0, gnt1, op32_0, op32_1, cin0, cin1;
    logic        done0, done1, cout0, cout1, add_ci_n, add_co_n;
    logic [31:0] a0, a1, b0, b1, res0, res1;
    logic [15:0] add_a, add_b, add_s;
    modport slave (
        input  req0, req1, op32_0, op32_1, a0, a1, b0, b1, cin0, cin1, add_s, add_co_n,
        output gnt0, gnt1, done0, done1, res0, res1, cout0, cout1, add_a, add_b, add_ci_n
    );
    modport master (
        output req0, req1, op32_0, op32_1, a0, a1, b0, b1, cin0, cin1, add_s, add_co_n,
        input  gnt0, gnt1, done0, done1, res0, res1, cout0, cout1, add_a, add_b, add_ci_n
    );
endinterface

// File: rtl/fas16_seq_arb.sv
// fas16_seq_arb: time-shares one 16-bit inverted-carry adder between two requesters, 16-bit ops in one pass, 32-bit in two
// Ports: sys_clk; reset (asynchronous, active-high); bus (fas16_seq_arb_if.slave) with both requester
//   handshakes (req/gnt/op32/a/b/cin -> done/res/cout) and the adder link (add_a/add_b/add_ci_n -> add_s/add_co_n).
// Parameters: W32_EN=1 honours op32 (two-pass add); PRIO=1 fixed priority to req0, PRIO=0 round-robin.
// Macro FAS16_SEQ_SAT_EN: when defined, a result that carries out saturates to all ones.
module fas16_seq_arb #(
    parameter bit W32_EN = 1'b1,
    parameter bit PRIO   = 1'b0
) (
    input logic            sys_clk,
    input logic            reset,
    fas16_seq_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    state_t      state_q;
    logic        own_q, rr_q, op32_q, cin_q, c_lo_q;
    logic        done0_q, done1_q, cout0_q, cout1_q;
    logic [15:0] lo_q;
    logic [31:0] a_q, b_q, res0_q, res1_q, res_w, res_d;
    logic        idle, win1, fin;

    assign idle = state_q == IDLE;
    // rr_q names the requester served last, so the other one wins a tie
    assign win1 = bus.req1 & ~(bus.req0 & (PRIO | rr_q));
    assign bus.gnt0 = idle & bus.req0 & ~win1;
    assign bus.gnt1 = idle & win1;
    assign fin = ((state_q == LO) & ~op32_q) | (state_q == HI);

    assign bus.add_a    = state_q == LO ? a_q[15:0] : state_q == HI ? a_q[31:16] : 16'h0;
    assign bus.add_b    = state_q == LO ? b_q[15:0] : state_q == HI ? b_q[31:16] : 16'h0;
    assign bus.add_ci_n = state_q == LO ? ~cin_q : state_q == HI ? ~c_lo_q : 1'b1;

    // low half is staged in lo_q so res only changes on the owner's done
    assign res_w = state_q == HI ? {bus.add_s, lo_q} : {16'h0, bus.add_s};
`ifdef FAS16_SEQ_SAT_EN
    assign res_d = ~bus.add_co_n ? (state_q == HI ? 32'hFFFF_FFFF : 32'h0000_FFFF) : res_w;
`else
    assign res_d = res_w;
`endif

    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.res0  = res0_q;
    assign bus.res1  = res1_q;
    assign bus.cout0 = cout0_q;
    assign bus.cout1 = cout1_q;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            rr_q    <= 1'b1;
            op32_q  <= 1'b0;
            cin_q   <= 1'b0;
            c_lo_q  <= 1'b0;
            lo_q    <= 16'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            res0_q  <= 32'h0;
            res1_q  <= 32'h0;
            cout0_q <= 1'b0;
            cout1_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            done0_q <= fin & ~own_q;
            done1_q <= fin & own_q;
            if (fin & ~own_q) begin
                res0_q  <= res_d;
                cout0_q <= ~bus.add_co_n;
            end
            if (fin & own_q) begin
                res1_q  <= res_d;
                cout1_q <= ~bus.add_co_n;
            end
            case (state_q)
                IDLE: if (bus.gnt0 | bus.gnt1) begin
                    own_q   <= win1;
                    rr_q    <= win1;
                    op32_q  <= W32_EN & (win1 ? bus.op32_1 : bus.op32_0);
                    a_q     <= win1 ? bus.a1 : bus.a0;
                    b_q     <= win1 ? bus.b1 : bus.b0;
                    cin_q   <= win1 ? bus.cin1 : bus.cin0;
                    state_q <= LO;
                end
                LO: begin
                    lo_q    <= bus.add_s;
                    c_lo_q  <= ~bus.add_co_n;
                    state_q <= op32_q ? HI : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
